tikreg_stage_seq: RTL
=====================

// Module: tikreg_stage_seq
// PURPOSE
//  Top-level sequencer for the Tikhonov pseudo-inverse pipeline. Launches STAGE_NUM processing stages in
//  order (hermitian, A^H*A, +lambda*I, inverse, ...): pulse start, wait for done, settle gap, next stage.
//  Drives bram_sel so one shared BRAM port is owned by exactly one stage at a time.
// PARAMETERS
//  STAGE_NUM      4      number of sequenced stages (>=1)
//  GAP_CYCLES     2      idle cycles between stage i done and stage i+1 start (>=0; covers BRAM write latency)
//  TIMEOUT_CYCLES 65536  per-stage watchdog limit in WAIT (used only with TIKREG_SEQ_TIMEOUT_EN)
//  SEL_WIDTH      $clog2(STAGE_NUM) (min 1)  width of bram_sel / stage_idx
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  start        in   1          run request, sampled in IDLE/ERR only
//  abort        in   1          synchronous abort, any state
//  stage_done   in   STAGE_NUM  per-stage done pulse (stage i -> bit i)
//  stage_start  out  STAGE_NUM  one-hot, one-cycle start pulse to stage i
//  bram_sel     out  SEL_WIDTH  index of stage owning shared BRAM port
//  busy         out  1          high from launch of stage 0 until final done / abort / error
//  done         out  1          one-cycle pulse: all stages completed
//  error        out  1          sticky watchdog error
// BEHAVIOUR
//  Reset: state=IDLE, stage_start=0, bram_sel=0, busy=0, done=0, error=0, stage_idx=0, counters=0.
//  All outputs registered. States: IDLE, LAUNCH, WAIT, GAP, ERR.
//  IDLE: start=1 at edge t -> stage_idx=0, bram_sel=0, stage_start=1<<0, busy=1 at edge t; -> LAUNCH.
//  LAUNCH: lasts exactly one cycle; stage_start cleared at next edge; -> WAIT. stage_done ignored here.
//  WAIT: only stage_done[stage_idx] is honoured; other bits ignored. Sampled high at edge u:
//   - stage_idx==STAGE_NUM-1: done=1, busy=0, stage_idx=0 at edge u; -> IDLE; done cleared next edge.
//   - else GAP_CYCLES==0: stage_idx+1, bram_sel, stage_start=1<<(stage_idx+1) at edge u; -> LAUNCH.
//   - else -> GAP; gap counter loaded; stage_start of next stage rises at edge u+GAP_CYCLES.
//  GAP: bram_sel keeps finished stage index until the next launch edge (no early ownership handoff).
//  start while busy: ignored (no restart, no queue). start and abort same edge: abort wins, stays IDLE.
//  abort (any state): at that edge -> IDLE, stage_start=0, busy=0, done=0, error=0, stage_idx=0,
//   bram_sel=0. abort beats a simultaneous stage_done (no done pulse).
//  stage_done[stage_idx] coincident with LAUNCH cycle is lost; stages guarantee >=2 cycles start->done.
//  stage_idx/gap counter never wrap: idx saturates at STAGE_NUM-1, GAP counter stops at 0.
//  Mid-run rst_n low: immediate return to reset values regardless of state.
// CONFIGURATION
//  TIKREG_SEQ_TIMEOUT_EN defined: cycle counter cleared at each launch, increments in WAIT; reaching
//   TIMEOUT_CYCLES without stage_done[stage_idx] -> ERR: error=1 (sticky), busy=0, stage_start=0,
//   bram_sel holds failing stage index. ERR exits on start (error cleared, run restarts at stage 0,
//   same edge) or abort (-> IDLE). stage_done on the timeout edge wins over the timeout.
//  Not defined: no counter, WAIT indefinitely, ERR unreachable, error tied 0.
// TESTING (STAGE_NUM=4, GAP_CYCLES=2, TIMEOUT_CYCLES=16 unless noted)
//  1 start edge 10; each stage answers done 5 cycles after its start -> stage_start bits 0..3 rise at
//    edges 10,17,24,31 (each 1 cycle); done pulse at edge 36; busy high edges 10..35; bram_sel 0,1,2,3.
//  2 GAP_CYCLES=0, done 3 cycles after start -> starts at 10,13,16,19; done at 22.
//  3 stage_done[2] pulsed while stage 0 in WAIT, start re-pulsed while busy -> both ignored, timeline of 1.
//  4 abort during GAP after stage 1 -> busy=0 next edge, no stage_start[2], no done; new start runs clean.
//  5 TIMEOUT_EN: stage 1 never done -> error=1 16 cycles after stage_start[1], busy=0, bram_sel=1;
//    start -> error=0, stage_start[0] same edge; without macro busy stays 1, error 0.
//  6 rst_n low while in WAIT of stage 2 -> all outputs 0 asynchronously; stays IDLE after release.

Source files
------------

// File: rtl/tikreg_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : tikreg_stage_seq
// Purpose  : Top-level sequencer for the Tikhonov pseudo-inverse pipeline.
//            Launches STAGE_NUM processing stages strictly in order:
//            one-cycle start pulse, wait for that stage's done, optional
//            settle gap, then the next stage. bram_sel names the single
//            stage that owns the shared BRAM port at any time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STAGE_NUM      number of sequenced stages (>= 1)
//   GAP_CYCLES     idle cycles between stage i done and stage i+1 start (>= 0)
//   TIMEOUT_CYCLES per-stage watchdog limit, cycles from launch (>= 2);
//                  only meaningful with TIKREG_SEQ_TIMEOUT_EN
//   SEL_WIDTH      width of bram_sel_o / stage index
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start_i        in   run request, honoured in IDLE and ERR only
//   abort_i        in   synchronous abort, any state, highest priority
//   stage_done_i   in   per-stage done pulse (stage i -> bit i)
//   stage_start_o  out  one-hot, one-cycle start pulse
//   bram_sel_o     out  index of the stage owning the shared BRAM port
//   busy_o         out  high while a run is in progress
//   done_o         out  one-cycle pulse when the last stage completes
//   error_o        out  sticky watchdog error
// Configuration macro
//   TIKREG_SEQ_TIMEOUT_EN  when defined, adds the per-stage watchdog and the
//                          ERR state; otherwise error_o is constant low.
// ============================================================================
module tikreg_stage_seq #(
    parameter int STAGE_NUM      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int SEL_WIDTH      = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [STAGE_NUM-1:0] stage_done_i,
    output logic [STAGE_NUM-1:0] stage_start_o,
    output logic [SEL_WIDTH-1:0] bram_sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(STAGE_NUM - 1);
    localparam int                   GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    // The gap counter is loaded on the done edge, so it only has to cover
    // the remaining GAP_CYCLES-1 edges before the launch edge.
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [STAGE_NUM-1:0]   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   launch;
    logic [SEL_WIDTH-1:0]   launch_idx;
    logic                   cur_done;
    logic [SEL_WIDTH-1:0]   next_idx;

`ifdef TIKREG_SEQ_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds cycles elapsed since the launch edge; the watchdog fires
    // on the edge that is TIMEOUT_CYCLES after launch.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   error_q, error_d;
`endif

    // Only the bit of the stage currently being waited on is honoured.
    assign cur_done = stage_done_i[idx_q];
    // Index saturates at the last stage; never wraps.
    assign next_idx = (idx_q == LAST_IDX) ? idx_q : idx_q + SEL_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        start_d    = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        launch     = 1'b0;
        launch_idx = '0;
`ifdef TIKREG_SEQ_TIMEOUT_EN
        tmo_d      = tmo_q;
        error_d    = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    launch = 1'b1;
                end
            end

            S_LAUNCH: begin
                // A done on this cycle is dropped; stages never answer this fast.
                state_d = S_WAIT;
`ifdef TIKREG_SEQ_TIMEOUT_EN
                tmo_d   = tmo_q + TMO_W'(1);
`endif
            end

            S_WAIT: begin
                if (cur_done) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        launch     = 1'b1;
                        launch_idx = next_idx;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
`ifdef TIKREG_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end

            S_GAP: begin
                // idx_q (and so bram_sel) keeps the finished stage until the
                // launch edge, so ownership moves exactly with the start pulse.
                if (gap_q == '0) begin
                    launch     = 1'b1;
                    launch_idx = next_idx;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

`ifdef TIKREG_SEQ_TIMEOUT_EN
            S_ERR: begin
                if (start_i) begin
                    launch  = 1'b1;
                    error_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            state_d = S_LAUNCH;
            idx_d   = launch_idx;
            start_d = STAGE_NUM'(1) << launch_idx;
            busy_d  = 1'b1;
`ifdef TIKREG_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end

        // Abort overrides everything above, including a coincident done.
        if (abort_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            gap_d   = '0;
            start_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
`ifdef TIKREG_SEQ_TIMEOUT_EN
            tmo_d   = '0;
            error_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TIKREG_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    // Watchdog compiled out: the comparison is false for any legal limit,
    // so error_o is a constant low.
    assign error_o = (TIMEOUT_CYCLES < 0);
`endif

    assign stage_start_o = start_q;
    assign bram_sel_o    = idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
`default_nettype wire
